// File: rtl/brissue_sched_pkg.sv
// Shared constants for the branch issue scheduler: default field widths,
// RV32 control-flow opcodes and the queue update encoding.
package brissue_sched_pkg;

    localparam int DEF_DEPTH        = 4;
    localparam int DEF_DATA_LEN     = 32;
    localparam int DEF_ADDR_LEN     = 32;
    localparam int DEF_RRF_SEL      = 6;
    localparam int DEF_SPECTAG_LEN  = 5;
    localparam int DEF_ALU_OP_WIDTH = 4;
    localparam int DEF_NUM_WB       = 2;

    localparam logic [6:0] RV32_OP_JAL    = 7'b1101111;
    localparam logic [6:0] RV32_OP_JALR   = 7'b1100111;
    localparam logic [6:0] RV32_OP_BRANCH = 7'b1100011;

    // Occupancy update selector: {dispatch, issue}
    typedef enum logic [1:0] {
        Q_HOLD  = 2'b00,
        Q_ISSUE = 2'b01,
        Q_DISP  = 2'b10,
        Q_BOTH  = 2'b11
    } q_act_e;

endpackage

// File: rtl/brissue_wakeup.sv
// Per-source tag match against the snooped writeback buses; the lowest
// matching bus index supplies the data.
module brissue_wakeup
#(
    parameter int NUM_WB   = 2,
    parameter int RRF_SEL  = 6,
    parameter int DATA_LEN = 32
)
(
    input  logic [RRF_SEL-1:0]         tag,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*RRF_SEL-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_LEN-1:0] wb_data,
    output logic                       hit,
    output logic [DATA_LEN-1:0]        data
);

    logic sel_s;

    // Scan from the highest bus down so the lowest index is applied last.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        sel_s = 1'b0;
        for (int b = NUM_WB - 1; b >= 0; b--) begin
            sel_s = wb_valid[b] && (wb_tag[b*RRF_SEL +: RRF_SEL] == tag);
            hit   = hit | sel_s;
            data  = sel_s ? wb_data[b*DATA_LEN +: DATA_LEN] : data;
        end
    end

endmodule

// File: rtl/brissue_sched.sv
// In-order issue queue for the branch unit: captures operands from the
// writeback buses and issues the oldest ready entry, flushing on mispredict.
module brissue_sched
    import brissue_sched_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DATA_LEN     = DEF_DATA_LEN,
    parameter int ADDR_LEN     = DEF_ADDR_LEN,
    parameter int RRF_SEL      = DEF_RRF_SEL,
    parameter int SPECTAG_LEN  = DEF_SPECTAG_LEN,
    parameter int ALU_OP_WIDTH = DEF_ALU_OP_WIDTH,
    parameter int NUM_WB       = DEF_NUM_WB
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [DATA_LEN-1:0]        disp_src1,
    input  logic [DATA_LEN-1:0]        disp_src2,
    input  logic                       disp_rdy1,
    input  logic                       disp_rdy2,
    input  logic [RRF_SEL-1:0]         disp_tag1,
    input  logic [RRF_SEL-1:0]         disp_tag2,
    input  logic [ADDR_LEN-1:0]        disp_pc,
    input  logic [ADDR_LEN-1:0]        disp_praddr,
    input  logic [DATA_LEN-1:0]        disp_imm,
    input  logic                       disp_dstval,
    input  logic [ALU_OP_WIDTH-1:0]    disp_alu_op,
    input  logic [6:0]                 disp_opcode,
    input  logic [SPECTAG_LEN-1:0]     disp_spectag,
    input  logic                       disp_specbit,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*RRF_SEL-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_LEN-1:0] wb_data,
    input  logic                       prmiss,
    input  logic                       prsuccess,
    input  logic [SPECTAG_LEN-1:0]     res_spectag,
    output logic                       issue,
    output logic [DATA_LEN-1:0]        ex_src1,
    output logic [DATA_LEN-1:0]        ex_src2,
    output logic [DATA_LEN-1:0]        ex_imm,
    output logic [ADDR_LEN-1:0]        ex_pc,
    output logic [ADDR_LEN-1:0]        ex_praddr,
    output logic                       ex_dstval,
    output logic [ALU_OP_WIDTH-1:0]    ex_alu_op,
    output logic [6:0]                 ex_opcode,
    output logic [SPECTAG_LEN-1:0]     ex_spectag,
    output logic                       ex_specbit,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]        valid_r;
    logic [DEPTH-1:0]        rdy1_r;
    logic [DEPTH-1:0]        rdy2_r;
    logic [DEPTH-1:0]        specbit_r;
    logic [DEPTH-1:0]        dstval_r;
    logic [DATA_LEN-1:0]     src1_r    [DEPTH];
    logic [DATA_LEN-1:0]     src2_r    [DEPTH];
    logic [DATA_LEN-1:0]     imm_r     [DEPTH];
    logic [RRF_SEL-1:0]      tag1_r    [DEPTH];
    logic [RRF_SEL-1:0]      tag2_r    [DEPTH];
    logic [ADDR_LEN-1:0]     pc_r      [DEPTH];
    logic [ADDR_LEN-1:0]     praddr_r  [DEPTH];
    logic [ALU_OP_WIDTH-1:0] alu_op_r  [DEPTH];
    logic [6:0]              opcode_r  [DEPTH];
    logic [SPECTAG_LEN-1:0]  spectag_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             issue_r;

    logic [DEPTH-1:0]    hit1_s;
    logic [DEPTH-1:0]    hit2_s;
    logic [DATA_LEN-1:0] wdata1_s [DEPTH];
    logic [DATA_LEN-1:0] wdata2_s [DEPTH];
    logic                dhit1_s;
    logic                dhit2_s;
    logic [DATA_LEN-1:0] ddata1_s;
    logic [DATA_LEN-1:0] ddata2_s;

    logic                do_disp_s;
    logic                do_issue_s;
    logic                spec_ok_s;
    q_act_e              q_act_s;

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_wake
        brissue_wakeup #(.NUM_WB(NUM_WB), .RRF_SEL(RRF_SEL), .DATA_LEN(DATA_LEN)) u_wake1 (
            .tag(tag1_r[g]), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
            .hit(hit1_s[g]), .data(wdata1_s[g])
        );
        brissue_wakeup #(.NUM_WB(NUM_WB), .RRF_SEL(RRF_SEL), .DATA_LEN(DATA_LEN)) u_wake2 (
            .tag(tag2_r[g]), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
            .hit(hit2_s[g]), .data(wdata2_s[g])
        );
    end

    brissue_wakeup #(.NUM_WB(NUM_WB), .RRF_SEL(RRF_SEL), .DATA_LEN(DATA_LEN)) u_byp1 (
        .tag(disp_tag1), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .hit(dhit1_s), .data(ddata1_s)
    );
    brissue_wakeup #(.NUM_WB(NUM_WB), .RRF_SEL(RRF_SEL), .DATA_LEN(DATA_LEN)) u_byp2 (
        .tag(disp_tag2), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .hit(dhit2_s), .data(ddata2_s)
    );

    assign disp_ready = (count_r < CNT_W'(DEPTH));
    assign count      = count_r;
    // Only combinational output path: squashes a wrong-path issue on mispredict.
    assign issue      = issue_r & ~prmiss;

    // Dispatch/issue qualification and occupancy action select.
    always_comb begin
        do_disp_s  = disp_valid & disp_ready & ~prmiss;
        do_issue_s = valid_r[head_r] & rdy1_r[head_r] & rdy2_r[head_r] & ~prmiss;
        spec_ok_s  = prsuccess & ~prmiss;
        q_act_s    = q_act_e'({do_disp_s, do_issue_s});
    end

    // Queue entry storage: wakeup, speculative-bit clear, dispatch write, flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r   <= '0;
            rdy1_r    <= '0;
            rdy2_r    <= '0;
            specbit_r <= '0;
            dstval_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src1_r[i]    <= '0;
                src2_r[i]    <= '0;
                imm_r[i]     <= '0;
                tag1_r[i]    <= '0;
                tag2_r[i]    <= '0;
                pc_r[i]      <= '0;
                praddr_r[i]  <= '0;
                alu_op_r[i]  <= '0;
                opcode_r[i]  <= '0;
                spectag_r[i] <= '0;
            end
        end else if (prmiss) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && !rdy1_r[i] && hit1_s[i]) begin
                    rdy1_r[i] <= 1'b1;
                    src1_r[i] <= wdata1_s[i];
                end
                if (valid_r[i] && !rdy2_r[i] && hit2_s[i]) begin
                    rdy2_r[i] <= 1'b1;
                    src2_r[i] <= wdata2_s[i];
                end
                if (spec_ok_s && valid_r[i] && (spectag_r[i] == res_spectag)) begin
                    specbit_r[i] <= 1'b0;
                end
            end
            if (do_issue_s) begin
                valid_r[head_r] <= 1'b0;
            end
            if (do_disp_s) begin
                valid_r[tail_r]   <= 1'b1;
                rdy1_r[tail_r]    <= disp_rdy1 | dhit1_s;
                rdy2_r[tail_r]    <= disp_rdy2 | dhit2_s;
                src1_r[tail_r]    <= (!disp_rdy1 && dhit1_s) ? ddata1_s : disp_src1;
                src2_r[tail_r]    <= (!disp_rdy2 && dhit2_s) ? ddata2_s : disp_src2;
                tag1_r[tail_r]    <= disp_tag1;
                tag2_r[tail_r]    <= disp_tag2;
                imm_r[tail_r]     <= disp_imm;
                pc_r[tail_r]      <= disp_pc;
                praddr_r[tail_r]  <= disp_praddr;
                dstval_r[tail_r]  <= disp_dstval;
                alu_op_r[tail_r]  <= disp_alu_op;
                opcode_r[tail_r]  <= disp_opcode;
                spectag_r[tail_r] <= disp_spectag;
                specbit_r[tail_r] <= disp_specbit & ~(spec_ok_s && (disp_spectag == res_spectag));
            end
        end
    end

    // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (prmiss) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_disp_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (do_issue_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case (q_act_s)
                Q_DISP:  count_r <= count_r + CNT_W'(1);
                Q_ISSUE: count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue register: loads the head entry on issue, otherwise holds the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_r    <= 1'b0;
            ex_src1    <= '0;
            ex_src2    <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            ex_praddr  <= '0;
            ex_dstval  <= 1'b0;
            ex_alu_op  <= '0;
            ex_opcode  <= '0;
            ex_spectag <= '0;
            ex_specbit <= 1'b0;
        end else if (do_issue_s) begin
            issue_r    <= 1'b1;
            ex_src1    <= src1_r[head_r];
            ex_src2    <= src2_r[head_r];
            ex_imm     <= imm_r[head_r];
            ex_pc      <= pc_r[head_r];
            ex_praddr  <= praddr_r[head_r];
            ex_dstval  <= dstval_r[head_r];
            ex_alu_op  <= alu_op_r[head_r];
            ex_opcode  <= opcode_r[head_r];
            ex_spectag <= spectag_r[head_r];
            ex_specbit <= specbit_r[head_r] & ~(spec_ok_s && (spectag_r[head_r] == res_spectag));
        end else begin
            issue_r <= 1'b0;
            if (spec_ok_s && issue_r && (ex_spectag == res_spectag)) begin
                ex_specbit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_brissue_sched.sv
// Directed self-checking bench for brissue_sched with hand-computed expectations.
module tb_brissue_sched;

    logic        clk;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    logic [31:0] disp_src1, disp_src2, disp_imm, disp_pc, disp_praddr;
    logic        disp_rdy1, disp_rdy2, disp_dstval, disp_specbit;
    logic [5:0]  disp_tag1, disp_tag2;
    logic [3:0]  disp_alu_op;
    logic [6:0]  disp_opcode;
    logic [4:0]  disp_spectag;
    logic [1:0]  wb_valid;
    logic [11:0] wb_tag;
    logic [63:0] wb_data;
    logic        prmiss, prsuccess;
    logic [4:0]  res_spectag;
    logic        issue;
    logic [31:0] ex_src1, ex_src2, ex_imm, ex_pc, ex_praddr;
    logic        ex_dstval, ex_specbit;
    logic [3:0]  ex_alu_op;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_spectag;
    logic [2:0]  count;

    int n_total = 0;
    int n_bad   = 0;
    int n_iss;

    brissue_sched dut (
        .clk(clk), .reset(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
        .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
        .disp_pc(disp_pc), .disp_praddr(disp_praddr), .disp_imm(disp_imm),
        .disp_dstval(disp_dstval), .disp_alu_op(disp_alu_op), .disp_opcode(disp_opcode),
        .disp_spectag(disp_spectag), .disp_specbit(disp_specbit),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .prmiss(prmiss), .prsuccess(prsuccess), .res_spectag(res_spectag),
        .issue(issue), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_praddr(ex_praddr), .ex_dstval(ex_dstval),
        .ex_alu_op(ex_alu_op), .ex_opcode(ex_opcode), .ex_spectag(ex_spectag),
        .ex_specbit(ex_specbit), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [5:0] t0, input logic [31:0] d0,
                          input logic [5:0] t1, input logic [31:0] d1);
        wb_valid = v;
        wb_tag   = {t1, t0};
        wb_data  = {d1, d0};
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [31:0] imm, input logic [6:0] op,
                            input logic r1, input logic [5:0] t1, input logic [31:0] s1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] s2,
                            input logic [4:0] st, input logic sb);
        disp_valid   = 1'b1;
        disp_pc      = pc;
        disp_praddr  = pc + 32'h40;
        disp_imm     = imm;
        disp_opcode  = op;
        disp_rdy1    = r1;
        disp_tag1    = t1;
        disp_src1    = s1;
        disp_rdy2    = r2;
        disp_tag2    = t2;
        disp_src2    = s2;
        disp_spectag = st;
        disp_specbit = sb;
        disp_dstval  = (op != 7'b1100011);
        disp_alu_op  = 4'd1;
        tick();
        disp_valid   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        disp_valid = 1'b0; disp_src1 = 32'd0; disp_src2 = 32'd0; disp_imm = 32'd0;
        disp_pc = 32'd0; disp_praddr = 32'd0; disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
        disp_dstval = 1'b0; disp_specbit = 1'b0; disp_tag1 = 6'd0; disp_tag2 = 6'd0;
        disp_alu_op = 4'd0; disp_opcode = 7'd0; disp_spectag = 5'd0;
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        prmiss = 1'b0; prsuccess = 1'b0; res_spectag = 5'd0;
        tick(); tick();
        check_eq("rst_count", count, 3'd0);
        check_eq("rst_issue", issue, 1'b0);
        check_eq("rst_ready", disp_ready, 1'b1);
        check_eq("rst_ex_pc", ex_pc, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: ready JAL issues two cycles after its dispatch cycle
        dispatch(32'h100, 32'h20, 7'b1101111, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2, 5'd0, 1'b0);
        check_eq("t1_cnt1", count, 3'd1);
        check_eq("t1_noiss", issue, 1'b0);
        tick();
        check_eq("t1_issue", issue, 1'b1);
        check_eq("t1_ex_pc", ex_pc, 32'h100);
        check_eq("t1_ex_imm", ex_imm, 32'h20);
        check_eq("t1_ex_op", ex_opcode, 7'b1101111);
        check_eq("t1_praddr", ex_praddr, 32'h140);
        check_eq("t1_cnt0", count, 3'd0);
        tick();
        check_eq("t1_drop", issue, 1'b0);

        // 2: BEQ waits on tag 5, woken on bus 1
        dispatch(32'h120, 32'h8, 7'b1100011, 1'b0, 6'd5, 32'h0, 1'b1, 6'd0, 32'h1234, 5'd0, 1'b0);
        tick(); tick();
        check_eq("t2_wait", issue, 1'b0);
        set_wb(2'b10, 6'd0, 32'd0, 6'd5, 32'hDEAD);
        tick();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        check_eq("t2_not_yet", issue, 1'b0);
        tick();
        check_eq("t2_issue", issue, 1'b1);
        check_eq("t2_src1", ex_src1, 32'hDEAD);
        check_eq("t2_src2", ex_src2, 32'h1234);
        check_eq("t2_pc", ex_pc, 32'h120);

        // bypass: tag 9 written back in the dispatch cycle itself
        set_wb(2'b01, 6'd9, 32'h9999, 6'd0, 32'd0);
        dispatch(32'h140, 32'h0, 7'b1100011, 1'b1, 6'd0, 32'h11, 1'b0, 6'd9, 32'h0, 5'd0, 1'b0);
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        tick();
        check_eq("byp_issue", issue, 1'b1);
        check_eq("byp_src2", ex_src2, 32'h9999);

        // lowest-index bus wins on a double match
        dispatch(32'h160, 32'h0, 7'b1100011, 1'b0, 6'd7, 32'h0, 1'b1, 6'd0, 32'h3, 5'd0, 1'b0);
        set_wb(2'b11, 6'd7, 32'hAAAA, 6'd7, 32'hBBBB);
        tick();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        tick();
        check_eq("prio_issue", issue, 1'b1);
        check_eq("prio_src1", ex_src1, 32'hAAAA);
        tick();

        // 3: fill to DEPTH, overflow dispatch ignored, drain
        for (int k = 0; k < 4; k++) begin
            dispatch(32'h200 + 32'(k * 4), 32'h0, 7'b1100011, 1'b0, 6'(10 + k), 32'h0,
                     1'b1, 6'd0, 32'h0, 5'd0, 1'b0);
        end
        check_eq("t3_full_cnt", count, 3'd4);
        check_eq("t3_full_rdy", disp_ready, 1'b0);
        dispatch(32'h300, 32'h0, 7'b1100011, 1'b0, 6'd14, 32'h0, 1'b1, 6'd0, 32'h0, 5'd0, 1'b0);
        check_eq("t3_ovf_cnt", count, 3'd4);
        set_wb(2'b01, 6'd10, 32'h10, 6'd0, 32'd0);
        tick();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        check_eq("t3_still_full", disp_ready, 1'b0);
        tick();
        check_eq("t3_issue0", issue, 1'b1);
        check_eq("t3_src0", ex_src1, 32'h10);
        check_eq("t3_cnt3", count, 3'd3);
        check_eq("t3_ready", disp_ready, 1'b1);
        set_wb(2'b11, 6'd11, 32'h11, 6'd12, 32'h12);
        tick();
        set_wb(2'b11, 6'd13, 32'h13, 6'd14, 32'h14);
        n_iss = 0;
        for (int k = 0; k < 6; k++) begin
            if (issue) n_iss++;
            tick();
            set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        end
        check_eq("t3_drain_n", n_iss, 3);
        check_eq("t3_drain_cnt", count, 3'd0);
        check_eq("t3_last_src", ex_src1, 32'h13);
        check_eq("t3_last_pc", ex_pc, 32'h20C);

        // 4: back-to-back issue, mispredict kills the second and flushes the third
        dispatch(32'h400, 32'h0, 7'b1100011, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 5'd0, 1'b0);
        dispatch(32'h404, 32'h0, 7'b1100011, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 5'd0, 1'b0);
        check_eq("t4_iss_a", issue, 1'b1);
        check_eq("t4_pc_a", ex_pc, 32'h400);
        dispatch(32'h408, 32'h0, 7'b1100011, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 5'd0, 1'b0);
        check_eq("t4_iss_b_raw", issue, 1'b1);
        check_eq("t4_pc_b", ex_pc, 32'h404);
        check_eq("t4_cnt1", count, 3'd1);
        prmiss = 1'b1;
        #1;
        check_eq("t4_kill", issue, 1'b0);
        tick();
        prmiss = 1'b0;
        check_eq("t4_flush_cnt", count, 3'd0);
        check_eq("t4_no_c", issue, 1'b0);
        tick();
        check_eq("t4_no_c2", issue, 1'b0);
        check_eq("t4_pc_hold", ex_pc, 32'h404);

        // 5: prsuccess clears specbit of queued entries with the matching tag only
        dispatch(32'h500, 32'h0, 7'b1100011, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 5'b00010, 1'b1);
        dispatch(32'h504, 32'h0, 7'b1100011, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h0, 5'b00010, 1'b1);
        check_eq("t5_a_pc", ex_pc, 32'h500);
        check_eq("t5_a_spec", ex_specbit, 1'b1);
        dispatch(32'h508, 32'h0, 7'b1100011, 1'b0, 6'd21, 32'h0, 1'b1, 6'd0, 32'h0, 5'b00100, 1'b1);
        prsuccess = 1'b1;
        res_spectag = 5'b00010;
        tick();
        prsuccess = 1'b0;
        res_spectag = 5'd0;
        check_eq("t5_ex_hold", ex_specbit, 1'b1);
        set_wb(2'b11, 6'd20, 32'h20, 6'd21, 32'h21);
        tick();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        tick();
        check_eq("t5_b_iss", issue, 1'b1);
        check_eq("t5_b_pc", ex_pc, 32'h504);
        check_eq("t5_b_spec", ex_specbit, 1'b0);
        tick();
        check_eq("t5_c_pc", ex_pc, 32'h508);
        check_eq("t5_c_spec", ex_specbit, 1'b1);
        tick();

        // 6: asynchronous reset mid-cycle with three entries still queued
        for (int k = 0; k < 4; k++) begin
            dispatch(32'h600 + 32'(k * 4), 32'h0, 7'b1100011, 1'b0, 6'(30 + k), 32'h0,
                     1'b1, 6'd0, 32'h0, 5'd0, 1'b0);
        end
        set_wb(2'b01, 6'd30, 32'h30, 6'd0, 32'd0);
        tick();
        set_wb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        tick();
        check_eq("t6_pre_iss", issue, 1'b1);
        check_eq("t6_pre_cnt", count, 3'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_iss", issue, 1'b0);
        check_eq("t6_rst_cnt", count, 3'd0);
        check_eq("t6_rst_pc", ex_pc, 32'd0);
        check_eq("t6_rst_rdy", disp_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_post_iss", issue, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
